// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared constants and types for the ALU sequencing controller.
//   - instruction field bit positions
//   - opcode values (OP_LOADI..OP_OR)
//   - ALU select encodings (aluop_t)
//   - controller state encoding (state_t)
`timescale 1ns/1ps
package alu_ctrl_pkg;

  // Instruction word layout: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm
  localparam int unsigned OPC_MSB  = 31;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC2_LSB = 0;
  localparam int unsigned IMM_LSB  = 0;
  localparam int unsigned FIELD_W  = 8;

  localparam logic [7:0] OP_LOADI = 8'd0;
  localparam logic [7:0] OP_MOV   = 8'd1;
  localparam logic [7:0] OP_ADD   = 8'd2;
  localparam logic [7:0] OP_SUB   = 8'd3;
  localparam logic [7:0] OP_AND   = 8'd4;
  localparam logic [7:0] OP_OR    = 8'd5;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOP = 3'b111
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXEC,
    WB
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational opcode decoder.
// Ports:
//   opcode  in   OPCODE_W  instruction opcode field
//   aluop   out  3         ALU select (ALU_NOP for undefined opcodes)
//   imm_sel out  1         DATA2 taken from the immediate (LOADI)
//   neg_sel out  1         DATA2 negated before the ALU (SUB)
//   legal   out  1         opcode is defined
`timescale 1ns/1ps
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  output aluop_t              aluop,
  output logic                imm_sel,
  output logic                neg_sel,
  output logic                legal
);

  always_comb begin
    aluop   = ALU_NOP;
    imm_sel = 1'b0;
    neg_sel = 1'b0;
    legal   = 1'b1;
    case (opcode)
      OPCODE_W'(OP_LOADI): begin aluop = ALU_FWD; imm_sel = 1'b1; end
      OPCODE_W'(OP_MOV):   aluop = ALU_FWD;
      OPCODE_W'(OP_ADD):   aluop = ALU_ADD;
      OPCODE_W'(OP_SUB):   begin aluop = ALU_ADD; neg_sel = 1'b1; end
      OPCODE_W'(OP_AND):   aluop = ALU_AND;
      OPCODE_W'(OP_OR):    aluop = ALU_OR;
      default:             legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: sequencing controller for the 8-bit ALU.
// Accepts an instruction on INSTR_VALID && INSTR_READY, holds the decoded
// controls for EXEC_CYCLES cycles, then pulses WRITEENABLE for one cycle.
// Ports:
//   CLK, RESET_N      clock, async active-low reset
//   INSTR, INSTR_VALID instruction word and valid
//   INSTR_READY       high in IDLE (and out of reset)
//   ALUOP             registered ALU select, ALU_NOP while idle
//   READREG1/2        registered source register addresses
//   WRITEREG          registered destination register address
//   IMMEDIATE         registered INSTR[7:0]
//   IMM_SEL, NEG_SEL  registered DATA2 selects
//   WRITEENABLE       one-cycle write strobe (WB state)
//   ILLEGAL           one-cycle pulse in DECODE for an undefined opcode
//   BUSY              high outside IDLE
`timescale 1ns/1ps
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 2,
  parameter int unsigned OPCODE_W    = 8,
  parameter int unsigned REG_ADDR_W  = 3
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [31:0]           INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [2:0]            ALUOP,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [7:0]            IMMEDIATE,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic                  WRITEENABLE,
  output logic                  ILLEGAL,
  output logic                  BUSY
);

  if (EXEC_CYCLES == 0 || EXEC_CYCLES > 15) begin : g_bad_exec_cycles
    $error("alu_ctrl_seq: EXEC_CYCLES=%0d outside 1..15", EXEC_CYCLES);
  end

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  aluop_t     aluop_q;
  logic       legal_q;
  logic       accept;

  aluop_t     dec_aluop;
  logic       dec_imm_sel;
  logic       dec_neg_sel;
  logic       dec_legal;

  // Upper bits of the register byte fields are intentionally dropped.
  logic unused_field_bits;
  assign unused_field_bits = ^{INSTR[DST_LSB+FIELD_W-1 : DST_LSB+REG_ADDR_W],
                               INSTR[SRC1_LSB+FIELD_W-1 : SRC1_LSB+REG_ADDR_W]};

  alu_op_decode #(
    .OPCODE_W (OPCODE_W)
  ) u_decode (
    .opcode  (INSTR[OPC_MSB -: OPCODE_W]),
    .aluop   (dec_aluop),
    .imm_sel (dec_imm_sel),
    .neg_sel (dec_neg_sel),
    .legal   (dec_legal)
  );

  assign accept      = INSTR_VALID && (state == IDLE);
  assign INSTR_READY = (state == IDLE) && RESET_N;
  assign BUSY        = (state != IDLE);
  assign WRITEENABLE = (state == WB);
  assign ILLEGAL     = (state == DECODE) && !legal_q;
  assign ALUOP       = aluop_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) state_nxt = DECODE;
      end
      DECODE: begin
        cnt_nxt   = '0;
        state_nxt = legal_q ? EXEC : IDLE;
      end
      EXEC: begin
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'(EXEC_CYCLES - 1)) state_nxt = WB;
      end
      WB: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Controls load only at the accept edge; on the way back to IDLE the ALU
  // select and DATA2 selects are parked while addresses/immediate are kept.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      aluop_q   <= ALU_NOP;
      legal_q   <= 1'b0;
      IMM_SEL   <= 1'b0;
      NEG_SEL   <= 1'b0;
      READREG1  <= '0;
      READREG2  <= '0;
      WRITEREG  <= '0;
      IMMEDIATE <= '0;
    end else if (accept) begin
      aluop_q   <= dec_aluop;
      legal_q   <= dec_legal;
      IMM_SEL   <= dec_imm_sel;
      NEG_SEL   <= dec_neg_sel;
      READREG1  <= INSTR[SRC1_LSB +: REG_ADDR_W];
      READREG2  <= INSTR[SRC2_LSB +: REG_ADDR_W];
      WRITEREG  <= INSTR[DST_LSB +: REG_ADDR_W];
      IMMEDIATE <= INSTR[IMM_LSB +: 8];
    end else if (state != IDLE && state_nxt == IDLE) begin
      aluop_q <= ALU_NOP;
      IMM_SEL <= 1'b0;
      NEG_SEL <= 1'b0;
    end
  end

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Sequencing control unit that drives the 8-bit ALU's 3-bit operation select. It accepts 32-bit instructions over a valid/ready handshake and decodes them into ALUOP, register addresses, immediate, immediate-select and negate-select. It holds those controls stable for the ALU's settle window, then pulses a single-cycle register-file write enable. It sits between instruction fetch and the register-file/ALU datapath.

Parameters:
EXEC_CYCLES, 2, cycles the controls are held in EXEC before write-back; legal range 1..15, sized for the ADD worst-case path.
OPCODE_W, 8, width of the opcode field (INSTR[31:24]).
REG_ADDR_W, 3, register address width; the low bits of each byte field are used.

Ports:
CLK  in  1  rising-edge clock.
RESET_N  in  1  asynchronous, active-low reset.
INSTR  in  32  instruction word: [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2/imm.
INSTR_VALID  in  1  instruction present on INSTR.
INSTR_READY  out  1  controller can accept an instruction (IDLE only).
ALUOP  out  3  ALU select: 000 FWD, 001 ADD, 010 AND, 011 OR, 111 NOP.
READREG1  out  REG_ADDR_W  source-1 register (INSTR[15:8] low bits).
READREG2  out  REG_ADDR_W  source-2 register (INSTR[7:0] low bits).
WRITEREG  out  REG_ADDR_W  destination register (INSTR[23:16] low bits).
IMMEDIATE  out  8  INSTR[7:0].
IMM_SEL  out  1  1 = ALU DATA2 taken from IMMEDIATE.
NEG_SEL  out  1  1 = DATA2 two's-complement negated before the ALU (SUB).
WRITEENABLE  out  1  one-cycle register-file write strobe.
ILLEGAL  out  1  one-cycle pulse when the opcode is undefined.
BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE, EXEC counter=0.
  - ALUOP=111; every other output 0, except INSTR_READY=1 while RESET_N=1 and state is IDLE.
  - Reset asserted mid-instruction aborts it: no WRITEENABLE is ever issued for it.
- States: IDLE, DECODE, EXEC, WB.
- IDLE:
  - INSTR_READY=1.
  - Accept on the rising edge where INSTR_VALID && INSTR_READY. At that edge, register all decoded fields and go to DECODE.
  - INSTR is ignored whenever INSTR_READY=0. VALID held high during BUSY does not queue a second instruction.
- Opcode decode:
  - 0 LOADI -> FWD, IMM_SEL=1.
  - 1 MOV -> FWD.
  - 2 ADD -> ADD.
  - 3 SUB -> ADD, NEG_SEL=1.
  - 4 AND -> AND.
  - 5 OR -> OR.
  - All other opcodes are illegal.
- DECODE (1 cycle):
  - Legal opcode -> EXEC with counter=0.
  - Illegal opcode -> ILLEGAL=1 this cycle, ALUOP=111, go straight to IDLE, no WRITEENABLE.
- EXEC:
  - Counter increments each cycle.
  - After EXEC_CYCLES cycles in EXEC -> WB.
- WB (1 cycle): WRITEENABLE=1, then IDLE.
- Output stability: ALUOP, READREG1/2, WRITEREG, IMMEDIATE, IMM_SEL and NEG_SEL are registered. They change only at the accept edge and hold through WB.
- After returning to IDLE: ALUOP returns to 111 and the selects return to 0. Register addresses and IMMEDIATE keep their last values.
- Latency with accept at edge k:
  - DECODE in cycle k+1.
  - EXEC in k+2 .. k+1+EXEC_CYCLES.
  - WRITEENABLE high during cycle k+2+EXEC_CYCLES.
  - INSTR_READY high again in cycle k+3+EXEC_CYCLES.
- Illegal-opcode latency: INSTR_READY is high again at cycle k+2.
- Upper bits of the register byte fields are ignored (e.g. dest 0x0C -> WRITEREG=4).
- EXEC_CYCLES outside 1..15 is a configuration error. Flag it with an elaboration-time check.

Decomposition:
- Package alu_ctrl_pkg holds:
  - Opcode constants: OP_LOADI..OP_OR.
  - ALUOP encodings: ALU_FWD, ALU_ADD, ALU_AND, ALU_OR, ALU_NOP=111.
  - State encoding: IDLE, DECODE, EXEC, WB.
  - The instruction field bit positions.
- Sub-module alu_op_decode: purely combinational opcode -> {ALUOP, IMM_SEL, NEG_SEL, legal}. The FSM, counter and output registers stay in alu_ctrl_seq.

Test Plan:
- Reset: RESET_N=0 asynchronously mid-cycle -> outputs immediately ALUOP=111, WRITEENABLE=0, BUSY=0; RESET_N=1 -> INSTR_READY=1.
- ADD, EXEC_CYCLES=2: INSTR=0x02040102 accepted at edge k -> from k+1: ALUOP=001, READREG1=1, READREG2=2, WRITEREG=4, IMM_SEL=0, NEG_SEL=0; WRITEENABLE=1 only in cycle k+4; INSTR_READY=1 at k+5.
- LOADI / SUB: 0x0003007F -> ALUOP=000, IMM_SEL=1, IMMEDIATE=0x7F, WRITEREG=3; 0x03050607 -> ALUOP=001, NEG_SEL=1, READREG1=6, READREG2=7, WRITEREG=5.
- Illegal: 0x09010203 -> ILLEGAL=1 for cycle k+1 only, ALUOP=111, no WRITEENABLE, INSTR_READY=1 at k+2.
- Back-to-back: INSTR_VALID held high with INSTR changing every cycle -> exactly one accept per completed instruction, each at an edge where INSTR_READY=1; intermediate INSTR values ignored.
- Reset mid-EXEC: assert RESET_N=0 during cycle k+2 of an ADD -> WRITEENABLE never pulses; after release the next ADD completes with normal latency.
